// File: rtl/grasspopper_pkg.sv
// grasspopper_pkg: shared widths and the adapter state type.
package grasspopper_pkg;

   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned BLOCK_BYTES = BLOCK_W / BYTE_W;
   localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES);

   typedef enum logic [1:0] {
      StFill,
      StReq,
      StWait,
      StDrain
   } state_e;

endpackage

// File: rtl/grasspopper_block_shifter.sv
// grasspopper_block_shifter: 16x8 block register with parallel load, byte shift-in at the
// low end, and a pad-fill that left-aligns a short block and fills the tail with PAD_BYTE.
module grasspopper_block_shifter
   import grasspopper_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_load,
   input  logic [BLOCK_W-1:0] i_load_data,
   input  logic               i_shift,
   input  logic [BYTE_W-1:0]  i_shift_byte,
   input  logic               i_pad,
   input  logic [CNT_W-1:0]   i_fill_idx,
   output logic [BLOCK_W-1:0] o_data
);

   localparam int unsigned SH_W = CNT_W + 3;

   logic [BLOCK_W-1:0] r_data;
   logic [BLOCK_W-1:0] w_shifted;
   logic [BLOCK_W-1:0] w_padded;
   logic [BLOCK_W-1:0] w_pad_fill;
   logic [BLOCK_W-1:0] w_low_mask;
   logic [CNT_W-1:0]   w_pad_bytes;
   logic [SH_W-1:0]    w_pad_sh;

   // Shift-in and pad alignment; i_fill_idx = bytes already held before this shift.
   always_comb begin
      w_shifted   = {r_data[BLOCK_W-BYTE_W-1:0], i_shift_byte};
      w_pad_bytes = CNT_W'(BLOCK_BYTES - 1) - i_fill_idx;
      w_pad_sh    = {w_pad_bytes, 3'b000};
      w_pad_fill  = {BLOCK_BYTES{PAD_BYTE}};
      w_low_mask  = ~({BLOCK_W{1'b1}} << w_pad_sh);
      w_padded    = (w_shifted << w_pad_sh) | (w_pad_fill & w_low_mask);
   end

   // Block register: load wins over shift.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
      end else if (i_shift) begin
         r_data <= i_pad ? w_padded : w_shifted;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/grasspopper_stream_adapter.sv
// grasspopper_stream_adapter: packs a byte stream into 128-bit blocks for the grasspopper
// core, runs the request/valid/ack handshake with a timeout, and streams results out as bytes.
module grasspopper_stream_adapter
   import grasspopper_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_BYTE       = 8'h00,
   parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [BYTE_W-1:0]  s_data_i,
   input  logic               s_valid_i,
   input  logic               s_last_i,
   output logic               s_ready_o,
   output logic [BLOCK_W-1:0] core_data_o,
   output logic               core_request_o,
   input  logic               core_busy_i,
   input  logic               core_valid_i,
   input  logic [BLOCK_W-1:0] core_data_i,
   output logic               core_ack_o,
   output logic [BYTE_W-1:0]  m_data_o,
   output logic               m_valid_o,
   output logic               m_last_o,
   input  logic               m_ready_i,
   output logic               error_o
);

   localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e             r_state;
   logic [CNT_W-1:0]   r_in_cnt;
   logic [CNT_W-1:0]   r_out_cnt;
   logic [TMO_W-1:0]   r_tmo;
   logic               r_s_ready;
   logic               r_core_request;
   logic               r_core_ack;
   logic               r_m_valid;
   logic               r_m_last;
   logic               r_last_flag;
   logic               r_error;

   logic               w_accept;
   logic               w_blk_end;
   logic               w_core_hit;
   logic               w_m_hs;
   logic [BLOCK_W-1:0] w_pack_block;
   logic [BLOCK_W-1:0] w_unpack_block;
   logic               w_unused_bits;

   // Handshake decodes; s_ready is only ever high in FILL.
   always_comb begin
      w_accept   = s_valid_i & r_s_ready;
      w_blk_end  = w_accept & (s_last_i | (r_in_cnt == CNT_W'(BLOCK_BYTES - 1)));
      // The request cycle itself is the first WAIT cycle; valid is ignored there.
      w_core_hit = (r_state == StWait) & ~r_core_request & core_valid_i;
      w_m_hs     = r_m_valid & m_ready_i;
   end

   grasspopper_block_shifter #(
      .PAD_BYTE (PAD_BYTE)
   ) u_pack (
      .clk          (clk),
      .resetn       (resetn),
      .i_load       (1'b0),
      .i_load_data  ('0),
      .i_shift      (w_accept),
      .i_shift_byte (s_data_i),
      .i_pad        (w_blk_end),
      .i_fill_idx   (r_in_cnt),
      .o_data       (w_pack_block)
   );

   grasspopper_block_shifter #(
      .PAD_BYTE (8'h00)
   ) u_unpack (
      .clk          (clk),
      .resetn       (resetn),
      .i_load       (w_core_hit),
      .i_load_data  (core_data_i),
      .i_shift      (w_m_hs),
      .i_shift_byte (8'h00),
      .i_pad        (1'b0),
      .i_fill_idx   ('0),
      .o_data       (w_unpack_block)
   );

   // Block sequencing FILL -> REQ -> WAIT -> DRAIN with all handshake outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= StFill;
         r_in_cnt       <= '0;
         r_out_cnt      <= '0;
         r_tmo          <= '0;
         r_s_ready      <= 1'b0;
         r_core_request <= 1'b0;
         r_core_ack     <= 1'b0;
         r_m_valid      <= 1'b0;
         r_m_last       <= 1'b0;
         r_last_flag    <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_core_request <= 1'b0;
         r_core_ack     <= 1'b0;
         unique case (r_state)
            StFill: begin
               r_s_ready <= 1'b1;
               if (w_accept) begin
                  if (w_blk_end) begin
                     r_state     <= StReq;
                     r_s_ready   <= 1'b0;
                     r_last_flag <= s_last_i;
                     r_in_cnt    <= '0;
                  end else begin
                     r_in_cnt <= r_in_cnt + CNT_W'(1);
                  end
               end
            end
            StReq: begin
               if (!core_busy_i) begin
                  r_core_request <= 1'b1;
                  r_tmo          <= '0;
                  r_state        <= StWait;
               end
            end
            StWait: begin
               if (w_core_hit) begin
                  r_core_ack <= 1'b1;
                  r_m_valid  <= 1'b1;
                  r_m_last   <= 1'b0;
                  r_out_cnt  <= '0;
                  r_state    <= StDrain;
               end else if (r_tmo == TMO_LAST) begin
                  // Core never answered: drop the block and flag it until reset.
                  r_error   <= 1'b1;
                  r_s_ready <= 1'b1;
                  r_state   <= StFill;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            StDrain: begin
               if (w_m_hs) begin
                  if (r_out_cnt == CNT_W'(BLOCK_BYTES - 1)) begin
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_s_ready <= 1'b1;
                     r_out_cnt <= '0;
                     r_state   <= StFill;
                  end else begin
                     r_out_cnt <= r_out_cnt + CNT_W'(1);
                     r_m_last  <= (r_out_cnt == CNT_W'(BLOCK_BYTES - 2)) & r_last_flag;
                  end
               end
            end
            default: r_state <= StFill;
         endcase
      end
   end

   assign w_unused_bits  = ^w_unpack_block[BLOCK_W-BYTE_W-1:0];

   assign s_ready_o      = r_s_ready;
   assign core_data_o    = w_pack_block;
   assign core_request_o = r_core_request;
   assign core_ack_o     = r_core_ack;
   assign m_data_o       = w_unpack_block[BLOCK_W-1 -: BYTE_W];
   assign m_valid_o      = r_m_valid;
   assign m_last_o       = r_m_last;
   assign error_o        = r_error;

endmodule
